// File: rtl/fmq_pkg.sv
// Shared definitions for the levitator command path: opcodes, field widths,
// deframer state encoding and small helpers.
package fmq_pkg;

  // Opcodes carried in byte0 bits [6:5]
  localparam logic [1:0] OP_SET_OFFSET = 2'd0;
  localparam logic [1:0] OP_RELOAD     = 2'd1;
  localparam logic [1:0] OP_QUERY      = 2'd2;
  localparam logic [1:0] OP_UNDEF      = 2'd3;

  // Field widths fixed by the 3-byte frame format
  localparam int FMQ_OFFSET_WIDTH = 11;
  localparam int FMQ_CHAN_WIDTH   = 8;

  // Deframer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GOT1 = 2'd1,
    ST_GOT2 = 2'd2,
    ST_HOLD = 2'd3
  } fmq_state_e;

  // A start byte is flagged by its MSB
  function automatic logic is_start(input logic [7:0] b);
    return b[7];
  endfunction

  // 8-bit increment that sticks at all-ones
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : (v + 8'd1);
  endfunction

endpackage

// File: rtl/fmq_cmd_timeout.sv
// Inter-byte timeout counter. Counts while run is high, restarts on clear or
// whenever run drops, and flags expired on the cycle whose edge would bring
// the count to TIMEOUT_CYCLES.
module fmq_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expired
);

  logic [15:0] cnt_r;

  // Cycle counter, held at zero outside a partial frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= 16'd0;
    end else if (clear || !run) begin
      cnt_r <= 16'd0;
    end else begin
      cnt_r <= cnt_r + 16'd1;
    end
  end

  assign expired = run && !clear && (cnt_r == 16'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fmq_cmd_deframer.sv
// Byte-to-command deframer: assembles 3-byte MSB-flagged frames from the UART
// receive stream and presents each command on a valid/ready handshake.
// Optional inter-byte timeout is enabled by defining CMD_TIMEOUT_EN.
module fmq_cmd_deframer
  import fmq_pkg::*;
#(
  parameter int OFFSET_WIDTH   = FMQ_OFFSET_WIDTH,
  parameter int CHAN_WIDTH     = FMQ_CHAN_WIDTH,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic [1:0]              cmd_op,
  output logic [CHAN_WIDTH-1:0]   cmd_channel,
  output logic [OFFSET_WIDTH-1:0] cmd_offset,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [7:0]              err_count
);

  fmq_state_e              state_r, next_state_s;
  logic                    rx_ready_r, cmd_valid_r;
  logic [1:0]              op_r;
  logic [CHAN_WIDTH-1:0]   chan_r;
  logic [OFFSET_WIDTH-1:0] off_r;
  logic [7:0]              err_r;

  logic accept_s;
  logic err_inc_s;
  logic latch0_s, latch1_s, latch2_s;
  logic run_s;
  logic expired_s;

  assign accept_s = rx_valid && rx_ready_r;
  assign run_s    = (state_r == ST_GOT1) || (state_r == ST_GOT2);

`ifdef CMD_TIMEOUT_EN
  fmq_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .run     (run_s),
    .clear   (accept_s),
    .expired (expired_s)
  );
`else
  logic [16:0] unused_timeout_s;
  assign unused_timeout_s = {run_s, 16'(TIMEOUT_CYCLES)};
  assign expired_s        = 1'b0;
`endif

  // Next-state, field-latch strobes and error strobe
  always_comb begin
    next_state_s = state_r;
    err_inc_s    = 1'b0;
    latch0_s     = 1'b0;
    latch1_s     = 1'b0;
    latch2_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (is_start(rx_data)) begin
            latch0_s     = 1'b1;
            next_state_s = ST_GOT1;
          end else begin
            err_inc_s = 1'b1;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_GOT1: begin
        if (accept_s) begin
          if (is_start(rx_data)) begin
            err_inc_s    = 1'b1;
            latch0_s     = 1'b1;
            next_state_s = ST_GOT1;
          end else begin
            latch1_s     = 1'b1;
            next_state_s = ST_GOT2;
          end
        end else if (expired_s) begin
          err_inc_s    = 1'b1;
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_GOT1;
        end
      end
      ST_GOT2: begin
        if (accept_s) begin
          if (is_start(rx_data)) begin
            err_inc_s    = 1'b1;
            latch0_s     = 1'b1;
            next_state_s = ST_GOT1;
          end else begin
            latch2_s     = 1'b1;
            next_state_s = ST_HOLD;
          end
        end else if (expired_s) begin
          err_inc_s    = 1'b1;
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_GOT2;
        end
      end
      ST_HOLD: begin
        if (cmd_valid_r && cmd_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_HOLD;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State register plus registered handshake flags derived from next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      rx_ready_r  <= 1'b0;
      cmd_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      rx_ready_r  <= (next_state_s != ST_HOLD);
      cmd_valid_r <= (next_state_s == ST_HOLD);
    end
  end

  // Command field capture; no bytes are accepted in HOLD so fields stay put
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r   <= 2'd0;
      chan_r <= '0;
      off_r  <= '0;
    end else begin
      if (latch0_s) begin
        op_r               <= rx_data[6:5];
        chan_r[CHAN_WIDTH-1:3] <= rx_data[4:0];
      end
      if (latch1_s) begin
        chan_r[2:0]            <= rx_data[6:4];
        off_r[OFFSET_WIDTH-1:7] <= rx_data[3:0];
      end
      if (latch2_s) begin
        off_r[6:0] <= rx_data[6:0];
      end
    end
  end

  // Saturating framing-error counter, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_r <= 8'd0;
    end else if (err_inc_s) begin
      err_r <= sat_inc8(err_r);
    end else begin
      err_r <= err_r;
    end
  end

  assign rx_ready    = rx_ready_r;
  assign cmd_valid   = cmd_valid_r;
  assign cmd_op      = op_r;
  assign cmd_channel = chan_r;
  assign cmd_offset  = off_r;
  assign err_count   = err_r;

endmodule

// File: tb/tb_fmq_cmd_deframer.sv
// Directed self-checking bench for fmq_cmd_deframer. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_fmq_cmd_deframer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_channel;
  logic [10:0] cmd_offset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  int cmd_seen = 0;
  int snap;

  fmq_cmd_deframer #(
    .OFFSET_WIDTH(11),
    .CHAN_WIDTH(8),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .cmd_op      (cmd_op),
    .cmd_channel (cmd_channel),
    .cmd_offset  (cmd_offset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  // Count completed handshakes
  always @(posedge clk) begin
    if (rst && cmd_valid && cmd_ready) cmd_seen <= cmd_seen + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one byte (called at a falling edge), return at the falling edge after acceptance
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'd1, 32'd0);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    cmd_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_fields", {11'd0, cmd_op, cmd_channel, cmd_offset}, 32'd0);
    chk("rst_err", {24'd0, err_count}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rx_ready_after_rst", {31'd0, rx_ready}, 32'd1);

    // Basic frame
    snap = cmd_seen;
    send_byte(8'h85); send_byte(8'h3A); send_byte(8'h55);
    chk("f1_valid", {31'd0, cmd_valid}, 32'd1);
    chk("f1_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("f1_op", {30'd0, cmd_op}, 32'd0);
    chk("f1_chan", {24'd0, cmd_channel}, 32'h2B);
    chk("f1_off", {21'd0, cmd_offset}, 32'h555);
    chk("f1_err", {24'd0, err_count}, 32'd0);
    @(negedge clk);
    chk("f1_done", {31'd0, cmd_valid}, 32'd0);
    chk("f1_count", cmd_seen - snap, 32'd1);

    // Start byte interrupts partial frame
    do_reset();
    snap = cmd_seen;
    send_byte(8'h85); send_byte(8'hA0); send_byte(8'h00); send_byte(8'h00);
    chk("f2_valid", {31'd0, cmd_valid}, 32'd1);
    chk("f2_op", {30'd0, cmd_op}, 32'd1);
    chk("f2_chan", {24'd0, cmd_channel}, 32'h00);
    chk("f2_off", {21'd0, cmd_offset}, 32'h000);
    chk("f2_err", {24'd0, err_count}, 32'd1);
    @(negedge clk);
    chk("f2_count", cmd_seen - snap, 32'd1);

    // Stray byte in IDLE then a good frame
    do_reset();
    send_byte(8'h12); send_byte(8'h85); send_byte(8'h00); send_byte(8'h01);
    chk("f3_chan", {24'd0, cmd_channel}, 32'h28);
    chk("f3_off", {21'd0, cmd_offset}, 32'h001);
    chk("f3_err", {24'd0, err_count}, 32'd1);
    @(negedge clk);

    // Back-pressure: executor holds off for 10 cycles while a byte is offered
    do_reset();
    cmd_ready = 1'b0;
    send_byte(8'hC5); send_byte(8'h3A); send_byte(8'h55);
    rx_data  = 8'h80;
    rx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {31'd0, cmd_valid}, 32'd1);
      chk("bp_rx_ready", {31'd0, rx_ready}, 32'd0);
      chk("bp_fields", {11'd0, cmd_op, cmd_channel, cmd_offset}, {11'd0, 2'd2, 8'h2B, 11'h555});
      @(negedge clk);
    end
    rx_valid  = 1'b0;
    cmd_ready = 1'b1;
    @(negedge clk);
    chk("bp_released_valid", {31'd0, cmd_valid}, 32'd0);
    chk("bp_released_ready", {31'd0, rx_ready}, 32'd1);
    send_byte(8'h00);
    chk("bp_byte_not_consumed", {24'd0, err_count}, 32'd1);

    // Reset mid-frame discards the partial frame
    do_reset();
    snap = cmd_seen;
    send_byte(8'h85); send_byte(8'h3A);
    rst = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, rx_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_byte(8'h55);
    chk("midrst_valid", {31'd0, cmd_valid}, 32'd0);
    chk("midrst_err", {24'd0, err_count}, 32'd1);
    chk("midrst_count", cmd_seen - snap, 32'd0);

    // Error counter saturation
    do_reset();
    rx_data  = 8'h00;
    rx_valid = 1'b1;
    repeat (300) @(negedge clk);
    chk("sat_err", {24'd0, err_count}, 32'd255);
    repeat (5) @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    chk("sat_hold", {24'd0, err_count}, 32'd255);

`ifdef CMD_TIMEOUT_EN
    // Inter-byte timeout drops the partial frame; the late byte is a stray
    do_reset();
    snap = cmd_seen;
    send_byte(8'h85); send_byte(8'h3A);
    repeat (100) @(negedge clk);
    send_byte(8'h55);
    @(negedge clk);
    chk("to_count", cmd_seen - snap, 32'd0);
    chk("to_err", {24'd0, err_count}, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
